// File: rtl/acc_ctrl_pkg.sv
// rtl/acc_ctrl_pkg.sv - opcode, ALU and state encodings for the accumulator CPU controller
// Contents:
//   OP_*      instruction opcodes carried in IR[15:8]
//   ALU_*     alu_op encodings driven towards the datapath ALU
//   state_t   controller state encoding (ST_PAUSE only with ACC_CTRL_SINGLE_STEP_EN)
//   needs_operand / alu_code  opcode classification helpers
package acc_ctrl_pkg;

    localparam logic [7:0] OP_NOP   = 8'h00;
    localparam logic [7:0] OP_LOAD  = 8'h01;
    localparam logic [7:0] OP_STORE = 8'h02;
    localparam logic [7:0] OP_ADD   = 8'h03;
    localparam logic [7:0] OP_SUB   = 8'h04;
    localparam logic [7:0] OP_JMP   = 8'h05;
    localparam logic [7:0] OP_JGEZ  = 8'h06;
    localparam logic [7:0] OP_HALT  = 8'h07;
    localparam logic [7:0] OP_AND   = 8'h08;
    localparam logic [7:0] OP_OR    = 8'h09;

    localparam logic [2:0] ALU_PASS_B = 3'b000;
    localparam logic [2:0] ALU_ADD    = 3'b001;
    localparam logic [2:0] ALU_SUB    = 3'b010;
    localparam logic [2:0] ALU_AND    = 3'b011;
    localparam logic [2:0] ALU_OR     = 3'b100;

    typedef enum logic [3:0] {
        ST_RST_IDLE,
        ST_FETCH_A,
        ST_FETCH_M,
        ST_DECODE,
        ST_OPR_A,
        ST_OPR_M,
        ST_EXEC,
        ST_STORE_M,
        ST_HALT
`ifdef ACC_CTRL_SINGLE_STEP_EN
        , ST_PAUSE
`endif
    } state_t;

    // Instructions that fetch (or write) a memory operand at IR[7:0].
    function automatic logic needs_operand(input logic [7:0] op);
        case (op)
            OP_LOAD, OP_STORE, OP_ADD, OP_SUB, OP_AND, OP_OR: return 1'b1;
            default:                                          return 1'b0;
        endcase
    endfunction

    function automatic logic [2:0] alu_code(input logic [7:0] op);
        case (op)
            OP_ADD:  return ALU_ADD;
            OP_SUB:  return ALU_SUB;
            OP_AND:  return ALU_AND;
            OP_OR:   return ALU_OR;
            default: return ALU_PASS_B;
        endcase
    endfunction

endpackage

// File: rtl/acc_ctrl_fsm_if.sv
// rtl/acc_ctrl_fsm_if.sv - controller <-> IR/memory/datapath signal bundle
// Modports:
//   slave   controller side: samples ir_opcode/acc_sign/mem_ack, drives all strobes
//   master  environment side: drives ir_opcode/acc_sign/mem_ack, observes strobes
interface acc_ctrl_fsm_if #(
    parameter int OPC_W = 8,
    parameter int CNT_W = 16
);
    logic [OPC_W-1:0] ir_opcode;
    logic             acc_sign;
    logic             mem_ack;
    logic             mar_sel_pc;
    logic             mar_load;
    logic             mem_rd;
    logic             mem_wr;
    logic             ir_load;
    logic             pc_inc;
    logic             pc_load;
    logic [2:0]       alu_op;
    logic             acc_alu_io_rw;
    logic             halted;
    logic [CNT_W-1:0] instr_retired;

    modport slave (
        input  ir_opcode, acc_sign, mem_ack,
        output mar_sel_pc, mar_load, mem_rd, mem_wr, ir_load, pc_inc, pc_load,
               alu_op, acc_alu_io_rw, halted, instr_retired
    );

    modport master (
        output ir_opcode, acc_sign, mem_ack,
        input  mar_sel_pc, mar_load, mem_rd, mem_wr, ir_load, pc_inc, pc_load,
               alu_op, acc_alu_io_rw, halted, instr_retired
    );
endinterface

// File: rtl/acc_ctrl_fsm.sv
// rtl/acc_ctrl_fsm.sv - multi-cycle fetch/decode/execute controller for the accumulator CPU
// Ports:
//   clk, rst_n   clock (rising edge), asynchronous active-low reset
//   step         single-step advance, only with ACC_CTRL_SINGLE_STEP_EN defined
//   bus          acc_ctrl_fsm_if.slave: ir_opcode/acc_sign/mem_ack in;
//                MAR/PC/IR/memory/ALU/ACC strobes, halted, instr_retired out
// Outputs are decoded from the state register (plus the opcode latched in DECODE),
// so reset clears every strobe asynchronously and mem_ack never reaches an output
// combinationally.
module acc_ctrl_fsm
    import acc_ctrl_pkg::*;
#(
    parameter int OPC_W = 8,
    parameter int CNT_W = 16
) (
    input  logic clk,
    input  logic rst_n,
`ifdef ACC_CTRL_SINGLE_STEP_EN
    input  logic step,
`endif
    acc_ctrl_fsm_if.slave bus
);

`ifdef ACC_CTRL_SINGLE_STEP_EN
    localparam state_t ST_NEXT_FETCH = ST_PAUSE;
`else
    localparam state_t ST_NEXT_FETCH = ST_FETCH_A;
`endif
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t           state;
    logic [OPC_W-1:0] opc_q;
    logic [CNT_W-1:0] retired_q;
    logic [7:0]       dec_opc;
    logic [7:0]       lat_opc;

    // DECODE acts on the live IR; later states only see the latched copy.
    assign dec_opc = 8'(bus.ir_opcode);
    assign lat_opc = 8'(opc_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_RST_IDLE;
            opc_q     <= '0;
            retired_q <= '0;
        end else begin
            case (state)
                ST_RST_IDLE: state <= ST_NEXT_FETCH;
                ST_FETCH_A:  state <= ST_FETCH_M;
                ST_FETCH_M:  if (bus.mem_ack) state <= ST_DECODE;
                ST_DECODE: begin
                    opc_q <= bus.ir_opcode;
                    if (needs_operand(dec_opc)) begin
                        state <= ST_OPR_A;
                    end else begin
                        // JMP/JGEZ/NOP/undefined finish here; HALT retires on entry.
                        state     <= (dec_opc == OP_HALT) ? ST_HALT : ST_NEXT_FETCH;
                        retired_q <= retired_q + CNT_ONE;
                    end
                end
                ST_OPR_A:    state <= (lat_opc == OP_STORE) ? ST_STORE_M : ST_OPR_M;
                ST_OPR_M:    if (bus.mem_ack) state <= ST_EXEC;
                ST_EXEC: begin
                    state     <= ST_NEXT_FETCH;
                    retired_q <= retired_q + CNT_ONE;
                end
                ST_STORE_M: begin
                    if (bus.mem_ack) begin
                        state     <= ST_NEXT_FETCH;
                        retired_q <= retired_q + CNT_ONE;
                    end
                end
                ST_HALT:     state <= ST_HALT;
`ifdef ACC_CTRL_SINGLE_STEP_EN
                ST_PAUSE:    if (step) state <= ST_FETCH_A;
`endif
                default:     state <= ST_RST_IDLE;
            endcase
        end
    end

    always_comb begin
        bus.mar_sel_pc    = 1'b0;
        bus.mar_load      = 1'b0;
        bus.mem_rd        = 1'b0;
        bus.mem_wr        = 1'b0;
        bus.ir_load       = 1'b0;
        bus.pc_inc        = 1'b0;
        bus.pc_load       = 1'b0;
        bus.alu_op        = ALU_PASS_B;
        bus.acc_alu_io_rw = 1'b0;
        bus.halted        = 1'b0;
        case (state)
            ST_FETCH_A: begin
                bus.mar_sel_pc = 1'b1;
                bus.mar_load   = 1'b1;
            end
            ST_FETCH_M: bus.mem_rd = 1'b1;
            ST_DECODE: begin
                bus.ir_load = 1'b1;
                bus.pc_inc  = 1'b1;
                if (dec_opc == OP_JMP)  bus.pc_load = 1'b1;
                if (dec_opc == OP_JGEZ) bus.pc_load = !bus.acc_sign;
            end
            ST_OPR_A:   bus.mar_load = 1'b1;
            ST_OPR_M:   bus.mem_rd   = 1'b1;
            ST_EXEC: begin
                bus.alu_op        = alu_code(lat_opc);
                bus.acc_alu_io_rw = 1'b1;
            end
            ST_STORE_M: bus.mem_wr = 1'b1;
            ST_HALT:    bus.halted = 1'b1;
            default: ;
        endcase
    end

    assign bus.instr_retired = retired_q;

endmodule

// File: tb/tb_acc_ctrl_fsm.sv
// tb/tb_acc_ctrl_fsm.sv - self-checking bench for acc_ctrl_fsm (default build)
module tb_acc_ctrl_fsm;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    acc_ctrl_fsm_if #(.OPC_W(8), .CNT_W(16)) bus ();

    acc_ctrl_fsm #(.OPC_W(8), .CNT_W(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // One expected bus cycle: inputs to drive, expected strobes, retire marker.
    typedef struct {
        logic       ack;
        logic [7:0] opc;
        logic [11:0] exp;
        bit         retire;
    } cyc_t;

    cyc_t trace[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   exp_cnt  = 0;

    function automatic logic [11:0] ov(input bit sel, input bit ld, input bit rd, input bit wr,
                                       input bit irl, input bit pci, input bit pcl,
                                       input logic [2:0] alu, input bit accw, input bit hlt);
        return {sel, ld, rd, wr, irl, pci, pcl, alu, accw, hlt};
    endfunction

    function automatic logic [11:0] obs();
        return {bus.mar_sel_pc, bus.mar_load, bus.mem_rd, bus.mem_wr, bus.ir_load,
                bus.pc_inc, bus.pc_load, bus.alu_op, bus.acc_alu_io_rw, bus.halted};
    endfunction

    function automatic logic [2:0] alu_of(input logic [7:0] op);
        case (op)
            8'h03:   return 3'd1;
            8'h04:   return 3'd2;
            8'h08:   return 3'd3;
            8'h09:   return 3'd4;
            default: return 3'd0;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
        n_checks++;
        assert (o === e) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, o, e);
        end
    endtask

    task automatic push(input logic ack, input logic [7:0] opc, input logic [11:0] e, input bit ret);
        cyc_t c;
        c.ack = ack;
        c.opc = opc;
        c.exp = e;
        c.retire = ret;
        trace.push_back(c);
    endtask

    // Expected cycle trace of one instruction: fd / od = wait cycles before the
    // fetch / operand ack, hc = cycles to observe after a HALT.
    task automatic build(input logic [7:0] op, input bit sign, input int fd, input int od, input int hc);
        push(1'($urandom), 8'($urandom), ov(1,1,0,0,0,0,0,3'd0,0,0), 0);
        for (int i = 0; i < fd; i++) push(1'b0, 8'($urandom), ov(0,0,1,0,0,0,0,3'd0,0,0), 0);
        push(1'b1, 8'($urandom), ov(0,0,1,0,0,0,0,3'd0,0,0), 0);
        case (op)
            8'h05: push(1'($urandom), op, ov(0,0,0,0,1,1,1,3'd0,0,0), 1);
            8'h06: push(1'($urandom), op, ov(0,0,0,0,1,1,!sign,3'd0,0,0), 1);
            8'h07: begin
                push(1'($urandom), op, ov(0,0,0,0,1,1,0,3'd0,0,0), 1);
                for (int i = 0; i < hc; i++) push(1'($urandom), 8'($urandom), ov(0,0,0,0,0,0,0,3'd0,0,1), 0);
            end
            8'h01, 8'h03, 8'h04, 8'h08, 8'h09: begin
                push(1'($urandom), op, ov(0,0,0,0,1,1,0,3'd0,0,0), 0);
                push(1'($urandom), 8'($urandom), ov(0,1,0,0,0,0,0,3'd0,0,0), 0);
                for (int i = 0; i < od; i++) push(1'b0, 8'($urandom), ov(0,0,1,0,0,0,0,3'd0,0,0), 0);
                push(1'b1, 8'($urandom), ov(0,0,1,0,0,0,0,3'd0,0,0), 0);
                push(1'($urandom), 8'($urandom), ov(0,0,0,0,0,0,0,alu_of(op),1,0), 1);
            end
            8'h02: begin
                push(1'($urandom), op, ov(0,0,0,0,1,1,0,3'd0,0,0), 0);
                push(1'($urandom), 8'($urandom), ov(0,1,0,0,0,0,0,3'd0,0,0), 0);
                for (int i = 0; i < od; i++) push(1'b0, 8'($urandom), ov(0,0,0,1,0,0,0,3'd0,0,0), 0);
                push(1'b1, 8'($urandom), ov(0,0,0,1,0,0,0,3'd0,0,0), 1);
            end
            default: push(1'($urandom), op, ov(0,0,0,0,1,1,0,3'd0,0,0), 1);
        endcase
    endtask

    // Replays the trace cycle by cycle; abort_at >= 0 stops before that cycle.
    task automatic run(input bit sign, input int abort_at, input string tag);
        cyc_t c;
        for (int k = 0; trace.size() > 0; k++) begin
            if (abort_at >= 0 && k == abort_at) begin
                trace.delete();
                break;
            end
            c = trace.pop_front();
            @(negedge clk);
            bus.mem_ack   = c.ack;
            bus.ir_opcode = c.opc;
            bus.acc_sign  = sign;
            #1;
            chk({tag, "_strobes"}, 32'(obs()), 32'(c.exp));
            chk({tag, "_retired"}, 32'(bus.instr_retired), 32'(exp_cnt[15:0]));
            if (c.retire) exp_cnt++;
        end
    endtask

    // Reset asserted mid-cycle: strobes must clear before any clock edge.
    task automatic do_reset();
        #2 rst_n = 1'b0;
        #1;
        chk("rst_async_strobes", 32'(obs()), 32'd0);
        chk("rst_async_retired", 32'(bus.instr_retired), 32'd0);
        exp_cnt = 0;
        repeat (2) @(negedge clk);
        bus.mem_ack = 1'b1;
        rst_n = 1'b1;
        #1;
        chk("rst_idle_strobes", 32'(obs()), 32'd0);
    endtask

    logic [7:0] ops [12];
    logic [7:0] op;
    bit         sg;

    initial begin
        ops = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h08, 8'h09, 8'h0A, 8'hFF, 8'h81};
        bus.mem_ack   = 1'b0;
        bus.ir_opcode = 8'h00;
        bus.acc_sign  = 1'b0;
        @(negedge clk);
        do_reset();

        for (int i = 0; i < 3; i++) begin
            build(8'h00, 1'b0, 0, 0, 0);
            run(1'b0, -1, "nop_loop");
        end

        build(8'h01, 1'b0, 0, 3, 0); run(1'b0, -1, "load_wait3");
        build(8'h06, 1'b1, 1, 0, 0); run(1'b1, -1, "jgez_neg");
        build(8'h06, 1'b0, 0, 0, 0); run(1'b0, -1, "jgez_pos");
        build(8'h05, 1'b1, 2, 0, 0); run(1'b1, -1, "jmp");
        build(8'h02, 1'b0, 0, 2, 0); run(1'b0, -1, "store");
        build(8'h03, 1'b0, 0, 0, 0); run(1'b0, -1, "add");
        build(8'h04, 1'b1, 1, 1, 0); run(1'b1, -1, "sub");
        build(8'h08, 1'b0, 0, 2, 0); run(1'b0, -1, "and");
        build(8'h09, 1'b0, 3, 0, 0); run(1'b0, -1, "or");

        for (int i = 0; i < 25; i++) begin
            op = ops[$urandom_range(0, 11)];
            sg = 1'($urandom);
            build(op, sg, $urandom_range(0, 3), $urandom_range(0, 3), 0);
            run(sg, -1, "random");
        end

        // Reset while OPR_M waits for its ack (two wait cycles already seen).
        build(8'h01, 1'b0, 0, 3, 0);
        run(1'b0, 6, "abort_oprm");
        do_reset();
        build(8'hFF, 1'b0, 0, 0, 0); run(1'b0, -1, "undef_ff");

        build(8'h07, 1'b0, 1, 0, 100); run(1'b0, -1, "halt");
        do_reset();
        build(8'h00, 1'b0, 0, 0, 0); run(1'b0, -1, "post_halt_nop");
        build(8'h01, 1'b1, 0, 0, 0); run(1'b1, -1, "post_halt_load");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
